// File: rtl/byte_serial_mem_transfer.sv
// byte_serial_mem_transfer
// Moves one multi-byte word between the datapath and a byte-wide memory,
// one byte per clock, behind a single Start/Done handshake.
//
// Build option: define TRANSFER_BIG_ENDIAN_EN to reverse the byte order
// within the N-byte field (address Addr+i carries word byte N-1-i).
// Without it the transfer is little-endian (Addr+i carries word byte i).
// Timing and handshake are the same in both builds.
//
// Handshake: Start is sampled only while Busy=0. A Start seen at a clock edge
// in IDLE is accepted at that edge and Busy rises for the following cycle.
// Start while Busy=1 is ignored (no queuing). Done is a single-cycle pulse in
// the last busy cycle; RData and AddrWrap are stable from Done until the next
// accepted Start.
//
// Debug: Dbg_State exposes the FSM state (0=IDLE, 1=XFER, 2=DRAIN, 3=DONE).

module byte_serial_mem_transfer #(
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 16,
    localparam int LEN_W     = $clog2(WORD_BYTES + 1),
    localparam int DATA_W    = 8 * WORD_BYTES
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Dir,
    input  logic [LEN_W-1:0]  Len,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] RData,
    output logic              AddrWrap,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [7:0]        Mem_Data,
    output logic              Mem_WR,
    output logic              Mem_CS,
    input  logic [7:0]        MemIn,
    output logic [1:0]        Dbg_State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Latched transfer parameters
    logic [ADDR_W-1:0] r_addr;
    logic              r_dir;
    logic [DATA_W-1:0] r_wdata;
    logic [LEN_W-1:0]  r_len;

    // Byte index of the access issued in the current XFER cycle
    logic [LEN_W-1:0]  r_idx;

    // Result registers
    logic [DATA_W-1:0] r_rdata;
    logic              r_wrap;

    // Derived combinational signals
    logic [LEN_W-1:0]  w_eff_len;
    logic [LEN_W-1:0]  w_last_idx;
    logic [LEN_W-1:0]  w_wr_pos;
    logic [LEN_W-1:0]  w_cap_idx;
    logic [LEN_W-1:0]  w_cap_pos;
    logic              w_cap_en;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [7:0]        w_wr_byte;
    logic              w_start_ok;

    assign RData     = r_rdata;
    assign AddrWrap  = r_wrap;
    assign Dbg_State = r_state;

    // Effective length: 0 or anything above WORD_BYTES means a full word
    always_comb begin
        w_eff_len = LEN_W'(WORD_BYTES);
        if ((Len != '0) && (Len <= LEN_W'(WORD_BYTES))) begin
            w_eff_len = Len;
        end
    end

    // Address and byte-lane selection for the access being issued, and for
    // the read byte being captured (which trails the issue by one cycle)
    always_comb begin
        w_last_idx = r_len - LEN_W'(1);
        w_cur_addr = r_addr + ADDR_W'(r_idx);
        // In DRAIN the outstanding byte is the last one issued
        if (r_state == S_DRAIN) begin
            w_cap_idx = w_last_idx;
        end else begin
            w_cap_idx = r_idx - LEN_W'(1);
        end
`ifdef TRANSFER_BIG_ENDIAN_EN
        w_wr_pos  = w_last_idx - r_idx;
        w_cap_pos = w_last_idx - w_cap_idx;
`else
        w_wr_pos  = r_idx;
        w_cap_pos = w_cap_idx;
`endif
        w_cap_en = ((r_state == S_XFER) && !r_dir && (r_idx != '0))
                 || (r_state == S_DRAIN);
    end

    // Pick the outgoing write byte from the latched word
    always_comb begin
        w_wr_byte = 8'h00;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (w_wr_pos == LEN_W'(b)) begin
                w_wr_byte = r_wdata[8*b +: 8];
            end
        end
    end

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and memory-port outputs; the port is quiet outside XFER
    always_comb begin
        w_next_state = r_state;
        w_start_ok   = 1'b0;
        Busy         = (r_state != S_IDLE);
        Done         = 1'b0;
        Mem_CS       = 1'b0;
        Mem_WR       = 1'b0;
        Mem_Address  = '0;
        Mem_Data     = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_start_ok   = 1'b1;
                    w_next_state = S_XFER;
                end
            end
            S_XFER: begin
                Mem_CS      = 1'b1;
                Mem_WR      = r_dir;
                Mem_Address = w_cur_addr;
                if (r_dir) begin
                    Mem_Data = w_wr_byte;
                end
                if (r_idx == w_last_idx) begin
                    // Reads need one more cycle for the final byte to return
                    w_next_state = r_dir ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                Done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: latch request, step the byte index, track wrap, capture reads
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_addr  <= '0;
            r_dir   <= 1'b0;
            r_wdata <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_wrap  <= 1'b0;
        end else if (w_start_ok) begin
            r_addr  <= Addr;
            r_dir   <= Dir;
            r_wdata <= WData;
            r_len   <= w_eff_len;
            r_idx   <= '0;
            r_rdata <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (r_state == S_XFER) begin
                r_idx <= r_idx + LEN_W'(1);
                // A modular address below the base means we passed the top
                if (w_cur_addr < r_addr) begin
                    r_wrap <= 1'b1;
                end
            end
            if (w_cap_en) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (w_cap_pos == LEN_W'(b)) begin
                        r_rdata[8*b +: 8] <= MemIn;
                    end
                end
            end
        end
    end

endmodule
